bcd_time_counter: RTL and testbench

//  Synchronous, parametrised HH:MM:SS time-of-day counter with BCD digit outputs for the 7-seg display path.

---
 rtl/bcd_time_pkg.sv | 31 +++
 rtl/bcd_mod_counter.sv | 38 +++
 rtl/bcd_time_counter.sv | 111 +++++++++++
 tb/tb_bcd_time_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_time_pkg.sv
// Shared types, moduli and BCD helpers for the HH:MM:SS time counter.
package bcd_time_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  // Two-digit BCD increment modulo mod, returned as {msb, lsb}.
  function automatic logic [7:0] bcd_next(input bcd_digit_t msb, input bcd_digit_t lsb,
                                          input int mod);
    bcd_digit_t max_msb;
    bcd_digit_t max_lsb;
    max_msb = 4'((mod - 1) / 10);
    max_lsb = 4'((mod - 1) % 10);
    if (msb == max_msb && lsb == max_lsb) return 8'h00;
    if (lsb == 4'd9) return {msb + 4'd1, 4'd0};
    return {msb, lsb + 4'd1};
  endfunction

  // Maps a stored 24 h BCD hour onto 12 h display digits (00 shows as 12).
  function automatic logic [7:0] bcd_to_12h(input bcd_digit_t hour_msb, input bcd_digit_t hour_lsb);
    logic [4:0] h;
    h = 5'(hour_msb) * 5'd10 + 5'(hour_lsb);
    if (h == 5'd0) h = 5'd12;
    else if (h > 5'd12) h = h - 5'd12;
    return {4'(h / 5'd10), 4'(h % 5'd10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD; wrap flags an increment out of MOD-1.
module bcd_mod_counter
  import bcd_time_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       carry_in,
  input  logic       clr,
  output logic [3:0] msb,
  output logic [3:0] lsb,
  output logic       wrap
);

  logic       step;
  logic       at_max;
  logic [7:0] nxt;

  assign step   = inc | carry_in;
  assign at_max = (msb == 4'((MOD - 1) / 10)) && (lsb == 4'((MOD - 1) % 10));
  assign wrap   = step & at_max;
  assign nxt    = bcd_next(msb, lsb, MOD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msb <= '0;
      lsb <= '0;
    end else if (clr) begin
      msb <= '0;
      lsb <= '0;
    end else if (step) begin
      {msb, lsb} <= nxt;
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with 1 s prescaler, 12/24 h display and set buttons.
// Optional alarm comparator is built when ALARM_EN is defined.
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter int CLK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic       mode12,
  input  logic       inc_sec,
  input  logic       inc_min,
  input  logic       inc_hour,
`ifdef ALARM_EN
  input  logic       alarm_arm,
  input  logic [3:0] alarm_hour_msb,
  input  logic [3:0] alarm_hour_lsb,
  input  logic [3:0] alarm_min_msb,
  input  logic [3:0] alarm_min_lsb,
  output logic       alarm_hit,
`endif
  output logic [3:0] sec_msb,
  output logic [3:0] sec_lsb,
  output logic [3:0] min_msb,
  output logic [3:0] min_lsb,
  output logic [3:0] hour_msb,
  output logic [3:0] hour_lsb,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap
);

  localparam int            PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic          any_inc;
  logic          tick_raw;
  logic          tick_adv;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hour_wrap;
  logic [3:0]    hr_msb;
  logic [3:0]    hr_lsb;
  logic [7:0]    hour12;

  assign any_inc  = inc_sec | inc_min | inc_hour;
  assign tick_raw = en && (presc == PRESC_MAX);
  // Clear and any manual increment swallow the tick for this cycle.
  assign tick_adv = tick_raw && !clr && !any_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (clr || inc_sec) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick_raw ? '0 : presc + PW'(1);
    end
  end

  bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk(clk), .reset(reset), .inc(inc_sec), .carry_in(tick_adv), .clr(clr),
    .msb(sec_msb), .lsb(sec_lsb), .wrap(sec_wrap)
  );

  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk(clk), .reset(reset), .inc(inc_min), .carry_in(tick_adv & sec_wrap), .clr(clr),
    .msb(min_msb), .lsb(min_lsb), .wrap(min_wrap)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .clk(clk), .reset(reset), .inc(inc_hour), .carry_in(tick_adv & min_wrap), .clr(clr),
    .msb(hr_msb), .lsb(hr_lsb), .wrap(hour_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      sec_tick <= tick_adv;
      day_wrap <= tick_adv & hour_wrap;
    end
  end

  assign hour12               = bcd_to_12h(hr_msb, hr_lsb);
  assign {hour_msb, hour_lsb} = mode12 ? hour12 : {hr_msb, hr_lsb};
  assign pm = (hr_msb == 4'd2) || ((hr_msb == 4'd1) && (hr_lsb >= 4'd2));

`ifdef ALARM_EN
  logic [7:0] min_next;
  logic [7:0] hour_next;
  logic       alarm_match;

  // Match against the time the tick is about to produce, so the pulse lines up with HH:MM:00.
  assign min_next    = bcd_next(min_msb, min_lsb, MIN_MOD);
  assign hour_next   = min_wrap ? bcd_next(hr_msb, hr_lsb, HOUR_MOD) : {hr_msb, hr_lsb};
  assign alarm_match = tick_adv && sec_wrap &&
                       (min_next == {alarm_min_msb, alarm_min_lsb}) &&
                       (hour_next == {alarm_hour_msb, alarm_hour_lsb});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alarm_hit <= 1'b0;
    else        alarm_hit <= alarm_arm & alarm_match;
  end
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter with CLK_DIV=4 (alarm steps need ALARM_EN).
module tb_bcd_time_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic mode12 = 1'b0;
  logic inc_sec = 1'b0;
  logic inc_min = 1'b0;
  logic inc_hour = 1'b0;
  logic [3:0] sec_msb, sec_lsb, min_msb, min_lsb, hour_msb, hour_lsb;
  logic pm, sec_tick, day_wrap;
`ifdef ALARM_EN
  logic alarm_arm = 1'b0;
  logic [3:0] alarm_hour_msb = 4'd0;
  logic [3:0] alarm_hour_lsb = 4'd0;
  logic [3:0] alarm_min_msb = 4'd0;
  logic [3:0] alarm_min_lsb = 4'd1;
  logic alarm_hit;
`endif

  logic [23:0] time_bcd;
  logic [23:0] hour_disp;
  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode12(mode12),
    .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour),
`ifdef ALARM_EN
    .alarm_arm(alarm_arm), .alarm_hour_msb(alarm_hour_msb), .alarm_hour_lsb(alarm_hour_lsb),
    .alarm_min_msb(alarm_min_msb), .alarm_min_lsb(alarm_min_lsb), .alarm_hit(alarm_hit),
`endif
    .sec_msb(sec_msb), .sec_lsb(sec_lsb), .min_msb(min_msb), .min_lsb(min_lsb),
    .hour_msb(hour_msb), .hour_lsb(hour_lsb), .pm(pm), .sec_tick(sec_tick), .day_wrap(day_wrap)
  );

  assign time_bcd  = {hour_msb, hour_lsb, min_msb, min_lsb, sec_msb, sec_lsb};
  assign hour_disp = {16'h0, hour_msb, hour_lsb};

  task automatic check_output(input string tag, input logic [23:0] observed, input logic [23:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clear, then preload h:m:s with parallel increment pulses (caller keeps en low).
  task automatic apply_stimulus(input int h, input int m, input int s);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i >= h && i >= m && i >= s) break;
      inc_hour = (i < h);
      inc_min  = (i < m);
      inc_sec  = (i < s);
      step(1);
    end
    inc_hour = 1'b0;
    inc_min  = 1'b0;
    inc_sec  = 1'b0;
  endtask

  initial begin
    #12;
    check_output("reset_time", time_bcd, 24'h000000);
    check_output("reset_tick", {23'h0, sec_tick}, 24'h0);
    check_output("reset_daywrap", {23'h0, day_wrap}, 24'h0);
    check_output("reset_pm", {23'h0, pm}, 24'h0);

    reset = 1'b1;
    en = 1'b1;
    step(3);
    check_output("run_before_tick", time_bcd, 24'h000000);
    step(1);
    check_output("run_first_tick", time_bcd, 24'h000001);
    check_output("run_sec_tick", {23'h0, sec_tick}, 24'h1);
    #2 reset = 1'b0;
    #1;
    check_output("async_reset_time", time_bcd, 24'h000000);
    check_output("async_reset_tick", {23'h0, sec_tick}, 24'h0);
    #2 reset = 1'b1;
    step(3);
    check_output("presc_restart_hold", time_bcd, 24'h000000);
    step(1);
    check_output("presc_restart_tick", time_bcd, 24'h000001);
    en = 1'b0;

    apply_stimulus(23, 59, 59);
    check_output("preload_235959", time_bcd, 24'h235959);
    en = 1'b1;
    step(3);
    check_output("pre_wrap_daywrap", {23'h0, day_wrap}, 24'h0);
    step(1);
    check_output("day_wrap_time", time_bcd, 24'h000000);
    check_output("day_wrap_pulse", {23'h0, day_wrap}, 24'h1);
    check_output("day_wrap_sectick", {23'h0, sec_tick}, 24'h1);
    step(1);
    check_output("day_wrap_clear", {23'h0, day_wrap}, 24'h0);
    check_output("sectick_clear", {23'h0, sec_tick}, 24'h0);
    en = 1'b0;

    apply_stimulus(0, 59, 30);
    inc_min = 1'b1;
    step(1);
    inc_min = 1'b0;
    check_output("inc_min_nocarry", time_bcd, 24'h000030);
    apply_stimulus(23, 10, 0);
    inc_hour = 1'b1;
    step(1);
    inc_hour = 1'b0;
    check_output("inc_hour_wrap", time_bcd, 24'h001000);
    check_output("inc_hour_no_daywrap", {23'h0, day_wrap}, 24'h0);

    mode12 = 1'b1;
    apply_stimulus(0, 0, 0);
    check_output("h12_midnight", hour_disp, 24'h000012);
    check_output("h12_midnight_pm", {23'h0, pm}, 24'h0);
    apply_stimulus(12, 0, 0);
    check_output("h12_noon", hour_disp, 24'h000012);
    check_output("h12_noon_pm", {23'h0, pm}, 24'h1);
    inc_hour = 1'b1;
    step(1);
    inc_hour = 1'b0;
    check_output("h12_13", hour_disp, 24'h000001);
    check_output("h12_13_pm", {23'h0, pm}, 24'h1);
    mode12 = 1'b0;
    #1;
    check_output("h24_stored_13", time_bcd, 24'h130000);
    mode12 = 1'b1;
    apply_stimulus(23, 0, 0);
    check_output("h12_23", hour_disp, 24'h000011);
    mode12 = 1'b0;

    apply_stimulus(0, 0, 5);
    en = 1'b1;
    step(3);
    inc_sec = 1'b1;
    step(1);
    inc_sec = 1'b0;
    check_output("inc_sec_vs_tick", time_bcd, 24'h000006);
    check_output("inc_sec_no_tick", {23'h0, sec_tick}, 24'h0);
    step(3);
    check_output("presc_zeroed_hold", time_bcd, 24'h000006);
    step(1);
    check_output("presc_zeroed_tick", time_bcd, 24'h000007);
    check_output("presc_zeroed_sectick", {23'h0, sec_tick}, 24'h1);
    en = 1'b0;

    apply_stimulus(0, 0, 10);
    en = 1'b1;
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check_output("clr_vs_tick", time_bcd, 24'h000000);
    check_output("clr_no_tick", {23'h0, sec_tick}, 24'h0);
    en = 1'b0;

`ifdef ALARM_EN
    alarm_arm = 1'b1;
    apply_stimulus(0, 0, 58);
    en = 1'b1;
    step(4);
    check_output("alarm_pre", {23'h0, alarm_hit}, 24'h0);
    step(4);
    check_output("alarm_time", time_bcd, 24'h000100);
    check_output("alarm_hit", {23'h0, alarm_hit}, 24'h1);
    step(1);
    check_output("alarm_single", {23'h0, alarm_hit}, 24'h0);
    en = 1'b0;
    alarm_arm = 1'b0;
    apply_stimulus(0, 0, 58);
    en = 1'b1;
    step(8);
    check_output("alarm_disarmed_time", time_bcd, 24'h000100);
    check_output("alarm_disarmed", {23'h0, alarm_hit}, 24'h0);
    en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
